typed_sequence_buffer: RTL and testbench
========================================

TYPED_SEQUENCE_BUFFER -- requirements
Module: typed_sequence_buffer

Interface
REQ-001 SHALL have parameter X_POS, default 9'd10, x origin passed to the sequence drawer.
REQ-002 SHALL have parameter Y_POS, default 9'd100, y origin passed to the sequence drawer.
REQ-003 SHALL have parameter PAD_CHAR, default 8'h20, code written into unused slots.
REQ-004 SHALL have parameter GUARD, default 4, hold cycles after each plot request.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port key_valid, input, 1, single-cycle strobe qualifying key_code.
REQ-008 SHALL have port key_code, input, 8, ASCII code of the pressed key.
REQ-009 SHALL have port ready_to_plot_sequence, input, 1, drawer idle indication.
REQ-010 SHALL have port sequence_, output, 88, plot snapshot; slot i occupies bits [87-8i:80-8i], slot 0 leftmost.
REQ-011 SHALL have port num_char, output, 8, constant 8'd10 (drawer renders slots 0..10).
REQ-012 SHALL have ports x_start and y_start, output, 9 each, constant X_POS and Y_POS.
REQ-013 SHALL have port plot_sequence, output, 1, single-cycle plot request.
REQ-014 SHALL have port char_count, output, 4, number of typed characters, 0..11.
REQ-015 SHALL have port buffer_full, output, 1, high while char_count == 11.
REQ-016 SHALL have port overflow, output, 1, single-cycle pulse when a printable key is dropped.
REQ-017 SHALL have port submit, output, 1, single-cycle pulse on Enter.
REQ-018 SHALL have port submit_sequence, output, 88, working buffer captured at the last Enter.

Function
REQ-019 SHALL keep an 11-slot working buffer and a separate 88-bit snapshot register that drives sequence_.
REQ-020 SHALL treat key_code 0x20..0x7E with key_valid as printable: if char_count < 11, write it to slot char_count and increment char_count.
REQ-021 SHALL drop a printable key when char_count == 11, leaving buffer and count unchanged, and pulse overflow on the following cycle.
REQ-022 SHALL treat 0x08 as backspace: if char_count > 0, write PAD_CHAR to slot char_count-1 and decrement char_count; if char_count == 0, ignore the key.
REQ-023 SHALL treat 0x0D as Enter: copy the pre-clear working buffer to submit_sequence, pulse submit on the next cycle, fill all slots with PAD_CHAR and set char_count to 0.
REQ-024 SHALL ignore all other key_code values, with no flag change.
REQ-025 SHALL set a dirty flag on every accepted edit (append, effective backspace, Enter) and SHALL NOT set it on dropped or ignored keys.
REQ-026 SHALL make an edit accepted at edge N visible on char_count and buffer_full after edge N.
REQ-027 SHALL implement a request FSM with states IDLE, REQUEST and HOLD.
REQ-028 IDLE -> REQUEST when dirty == 1 and ready_to_plot_sequence == 1; otherwise stay in IDLE.
REQ-029 In REQUEST, for exactly one cycle: plot_sequence = 1; the snapshot register loads the working buffer as registered in that cycle; dirty clears.
REQ-030 REQUEST -> HOLD unconditionally; HOLD lasts GUARD cycles counted by a down-counter, then -> IDLE.
REQ-031 sequence_ SHALL remain constant from the REQUEST cycle through the end of HOLD.
REQ-032 An edit accepted in the same cycle as the REQUEST dirty-clear SHALL win: dirty stays 1, and that edit is excluded from the current snapshot.
REQ-033 Edits during REQUEST/HOLD SHALL update only the working buffer and dirty flag; one further request follows after HOLD.
REQ-034 plot_sequence SHALL never be high on two consecutive cycles, nor in IDLE or HOLD.

Reset
REQ-035 On reset high at a clock edge, the block SHALL set: working buffer, snapshot and submit_sequence all PAD_CHAR; char_count 0; dirty 1; FSM IDLE; HOLD counter 0; plot_sequence, overflow, submit 0.
REQ-036 Reset SHALL take priority over any simultaneous key_valid or FSM transition, including mid-HOLD.

Verification
REQ-037 Reset, ready=1 -> plot_sequence pulses once; sequence_ = 88 bits of 0x20 repeated; no further pulse.
REQ-038 Type 'C','A','T', ready=1 -> char_count 3; the final snapshot has sequence_[87:64] = 0x434154 and the rest 0x20.
REQ-039 Type 12 printable keys -> char_count 11, buffer_full 1, overflow pulses once on the 12th key, slot 10 holds the 11th key.
REQ-040 Type 'AB' then 0x08, 0x08, 0x08 -> char_count 0 and all slots 0x20, dirty set by only two of the three backspaces.
REQ-041 Type 'HI' then 0x0D -> submit pulses, submit_sequence[87:72] = 0x4849, char_count 0, a blank redraw is requested.
REQ-042 Key edit on the REQUEST cycle, with ready held 1 -> the current snapshot excludes the key; a second plot_sequence fires exactly GUARD+1 cycles after the first.

Source files
------------

// File: rtl/typed_sequence_buffer.sv
// typed_sequence_buffer
//   Collects keystrokes into an 11-slot character buffer and hands snapshots
//   of it to a sequence drawer. Printable keys append, backspace removes the
//   last character, Enter submits the buffer and clears it. Any accepted edit
//   marks the buffer dirty; a small request FSM then issues one plot request
//   while the drawer is ready and freezes the drawn snapshot for GUARD cycles.
//
// Ports
//   clk, reset               : clock, synchronous active-high reset
//   key_valid, key_code      : one-cycle key strobe and its ASCII code
//   ready_to_plot_sequence   : drawer idle indication
//   sequence_                : frozen snapshot, slot 0 in bits [87:80]
//   num_char, x_start/y_start: constant drawer configuration
//   plot_sequence            : one-cycle plot request
//   char_count, buffer_full  : number of typed characters, full flag
//   overflow                 : one-cycle pulse when a printable key is dropped
//   submit, submit_sequence  : one-cycle Enter pulse, buffer captured at Enter
module typed_sequence_buffer #(
    parameter logic [8:0]  X_POS    = 9'd10,
    parameter logic [8:0]  Y_POS    = 9'd100,
    parameter logic [7:0]  PAD_CHAR = 8'h20,
    parameter int unsigned GUARD    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic        ready_to_plot_sequence,
    output logic [87:0] sequence_,
    output logic [7:0]  num_char,
    output logic [8:0]  x_start,
    output logic [8:0]  y_start,
    output logic        plot_sequence,
    output logic [3:0]  char_count,
    output logic        buffer_full,
    output logic        overflow,
    output logic        submit,
    output logic [87:0] submit_sequence
);

    localparam int unsigned SLOTS = 11;
    localparam int unsigned CW    = $clog2(GUARD + 1);
    localparam logic [3:0]  FULL  = 4'd11;

    typedef enum logic [1:0] {IDLE, REQUEST, HOLD} state_t;

    state_t       state_q;
    logic [CW-1:0] hold_cnt_q;
    logic [7:0]   work_q [SLOTS];
    logic [7:0]   work_d [SLOTS];
    logic [3:0]   count_q;
    logic [3:0]   count_d;
    logic         dirty_q;
    logic [87:0]  snap_q;
    logic [87:0]  work_q_flat;
    logic [87:0]  work_d_flat;
    logic         edit;
    logic         drop;
    logic         enter;

    // Key decode and next working buffer
    always_comb begin
        for (int unsigned i = 0; i < SLOTS; i++) work_d[i] = work_q[i];
        count_d = count_q;
        edit    = 1'b0;
        drop    = 1'b0;
        enter   = 1'b0;
        if (key_valid) begin
            if (key_code >= 8'h20 && key_code <= 8'h7E) begin
                if (count_q < FULL) begin
                    work_d[count_q] = key_code;
                    count_d         = count_q + 4'd1;
                    edit            = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (key_code == 8'h08) begin
                if (count_q != 4'd0) begin
                    work_d[count_q - 4'd1] = PAD_CHAR;
                    count_d                = count_q - 4'd1;
                    edit                   = 1'b1;
                end
            end else if (key_code == 8'h0D) begin
                for (int unsigned i = 0; i < SLOTS; i++) work_d[i] = PAD_CHAR;
                count_d = 4'd0;
                edit    = 1'b1;
                enter   = 1'b1;
            end
        end
    end

    always_comb begin
        work_q_flat = '0;
        work_d_flat = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            work_q_flat[87 - 8*i -: 8] = work_q[i];
            work_d_flat[87 - 8*i -: 8] = work_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SLOTS; i++) work_q[i] <= PAD_CHAR;
            count_q         <= 4'd0;
            dirty_q         <= 1'b1;
            snap_q          <= {SLOTS{PAD_CHAR}};
            submit_sequence <= {SLOTS{PAD_CHAR}};
            state_q         <= IDLE;
            hold_cnt_q      <= '0;
            plot_sequence   <= 1'b0;
            overflow        <= 1'b0;
            submit          <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SLOTS; i++) work_q[i] <= work_d[i];
            count_q  <= count_d;
            overflow <= drop;
            submit   <= enter;
            if (enter) submit_sequence <= work_q_flat;

            // An edit landing on the REQUEST cycle keeps the buffer dirty.
            if (edit)                    dirty_q <= 1'b1;
            else if (state_q == REQUEST) dirty_q <= 1'b0;

            // The snapshot takes the buffer value visible during the REQUEST
            // cycle, so it is frozen for the whole REQUEST + HOLD window.
            plot_sequence <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dirty_q && ready_to_plot_sequence) begin
                        state_q       <= REQUEST;
                        plot_sequence <= 1'b1;
                        snap_q        <= work_d_flat;
                    end
                end
                REQUEST: begin
                    state_q    <= HOLD;
                    hold_cnt_q <= CW'(GUARD);
                end
                HOLD: begin
                    hold_cnt_q <= hold_cnt_q - CW'(1);
                    // Last HOLD cycle makes the IDLE decision itself, so a
                    // pending edit is requested GUARD+1 cycles after the last.
                    if (hold_cnt_q <= CW'(1)) begin
                        if (dirty_q && ready_to_plot_sequence) begin
                            state_q       <= REQUEST;
                            plot_sequence <= 1'b1;
                            snap_q        <= work_d_flat;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sequence_   = snap_q;
    assign num_char    = 8'd10;
    assign x_start     = X_POS;
    assign y_start     = Y_POS;
    assign char_count  = count_q;
    assign buffer_full = (count_q == FULL);

endmodule

// File: tb/tb_typed_sequence_buffer.sv
// Testbench for typed_sequence_buffer: directed scenarios plus a randomized
// run, all checked against a rule-level model (character queue, dirty flag,
// and "a plot may follow GUARD cycles after the previous one").
module tb_typed_sequence_buffer;

    localparam int unsigned GUARD = 4;
    localparam logic [7:0]  PAD   = 8'h20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic        ready = 1'b0;
    logic [87:0] sequence_;
    logic [7:0]  num_char;
    logic [8:0]  x_start;
    logic [8:0]  y_start;
    logic        plot_sequence;
    logic [3:0]  char_count;
    logic        buffer_full;
    logic        overflow;
    logic        submit;
    logic [87:0] submit_sequence;

    always #5 clk = ~clk;

    typed_sequence_buffer #(
        .X_POS(9'd10), .Y_POS(9'd100), .PAD_CHAR(PAD), .GUARD(GUARD)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .ready_to_plot_sequence(ready), .sequence_(sequence_), .num_char(num_char),
        .x_start(x_start), .y_start(y_start), .plot_sequence(plot_sequence),
        .char_count(char_count), .buffer_full(buffer_full), .overflow(overflow),
        .submit(submit), .submit_sequence(submit_sequence)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, as visible in the current cycle
    logic [7:0]  m_buf[$];
    bit          m_dirty;
    int          m_cycle;
    int          m_last;
    bit          m_plot;
    bit          m_ovf;
    bit          m_sub;
    logic [87:0] m_snap;
    logic [87:0] m_subseq;

    function automatic logic [87:0] pack_model();
        logic [87:0] v;
        v = '0;
        for (int i = 0; i < 11; i++)
            v[87 - 8*i -: 8] = (i < m_buf.size()) ? m_buf[i] : PAD;
        return v;
    endfunction

    // Apply inputs for one cycle, advance to just after the edge, update model.
    task automatic tick(input bit rst, input bit kv, input logic [7:0] kc, input bit rdy);
        bit edit;
        bit nplot;
        reset = rst; key_valid = kv; key_code = kc; ready = rdy;
        @(posedge clk);
        #1;
        if (rst) begin
            m_buf.delete();
            m_dirty = 1'b1; m_cycle = 0; m_last = -1000;
            m_plot = 1'b0; m_ovf = 1'b0; m_sub = 1'b0;
            m_snap = {11{PAD}}; m_subseq = {11{PAD}};
        end else begin
            edit = 1'b0; m_ovf = 1'b0; m_sub = 1'b0;
            if (kv) begin
                if (kc >= 8'h20 && kc <= 8'h7E) begin
                    if (m_buf.size() < 11) begin m_buf.push_back(kc); edit = 1'b1; end
                    else m_ovf = 1'b1;
                end else if (kc == 8'h08) begin
                    if (m_buf.size() > 0) begin void'(m_buf.pop_back()); edit = 1'b1; end
                end else if (kc == 8'h0D) begin
                    m_subseq = pack_model();
                    m_buf.delete();
                    edit = 1'b1; m_sub = 1'b1;
                end
            end
            nplot   = m_dirty && rdy && (m_cycle - m_last >= int'(GUARD));
            m_dirty = edit ? 1'b1 : (m_plot ? 1'b0 : m_dirty);
            m_cycle++;
            m_plot = nplot;
            if (nplot) begin m_last = m_cycle; m_snap = pack_model(); end
        end
    endtask

    task automatic test_reset();
        tick(1, 1, 8'h41, 1);   // key and ready during reset are ignored
        n_cmp++; if (plot_sequence !== 1'b0) begin n_err++; $display("FAIL reset_plot: got %b expected 0", plot_sequence); end
        n_cmp++; if (char_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", char_count); end
        n_cmp++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", buffer_full); end
        n_cmp++; if (sequence_ !== {11{PAD}}) begin n_err++; $display("FAIL reset_seq: got %h expected %h", sequence_, {11{PAD}}); end
        n_cmp++; if (submit_sequence !== {11{PAD}}) begin n_err++; $display("FAIL reset_subseq: got %h expected %h", submit_sequence, {11{PAD}}); end
        n_cmp++; if ({overflow, submit} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b expected 00", {overflow, submit}); end
        n_cmp++; if ({num_char, x_start, y_start} !== {8'd10, 9'd10, 9'd100}) begin n_err++; $display("FAIL consts: got %0d/%0d/%0d expected 10/10/100", num_char, x_start, y_start); end
        // Reset in the middle of HOLD
        tick(0, 0, 8'h00, 1);
        tick(0, 1, 8'h5A, 1);
        tick(1, 1, 8'h5A, 1);
        n_cmp++; if ({plot_sequence, char_count} !== 5'd0) begin n_err++; $display("FAIL midhold_reset: got plot=%b count=%0d expected 0/0", plot_sequence, char_count); end
        tick(0, 0, 8'h00, 1);
        n_cmp++; if (plot_sequence !== 1'b1) begin n_err++; $display("FAIL post_reset_plot: got %b expected 1", plot_sequence); end
    endtask

    task automatic test_blank_plot();
        int plots;
        plots = 0;
        tick(1, 0, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 8'h00, 1);
            if (plot_sequence) plots++;
            n_cmp++; if (plot_sequence !== m_plot) begin n_err++; $display("FAIL blank_plot_cyc%0d: got %b expected %b", i, plot_sequence, m_plot); end
        end
        n_cmp++; if (plots != 1) begin n_err++; $display("FAIL blank_plot_count: got %0d expected 1", plots); end
        n_cmp++; if (sequence_ !== {11{PAD}}) begin n_err++; $display("FAIL blank_seq: got %h expected %h", sequence_, {11{PAD}}); end
    endtask

    task automatic test_cat();
        int plots;
        plots = 0;
        tick(1, 0, 8'h00, 0);
        tick(0, 1, 8'h43, 0);
        tick(0, 1, 8'h41, 0);
        tick(0, 1, 8'h54, 0);
        for (int i = 0; i < 2 * GUARD + 4; i++) begin
            tick(0, 0, 8'h00, 1);
            if (plot_sequence) plots++;
        end
        n_cmp++; if (char_count !== 4'd3) begin n_err++; $display("FAIL cat_count: got %0d expected 3", char_count); end
        n_cmp++; if (sequence_ !== {24'h434154, {8{PAD}}}) begin n_err++; $display("FAIL cat_seq: got %h expected %h", sequence_, {24'h434154, {8{PAD}}}); end
        n_cmp++; if (plots != 1) begin n_err++; $display("FAIL cat_plots: got %0d expected 1", plots); end
    endtask

    task automatic test_overflow();
        int ovf;
        ovf = 0;
        tick(1, 0, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            tick(0, 1, 8'h61 + 8'(i), 0);
            if (overflow) ovf++;
        end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
        n_cmp++; if (char_count !== 4'd11) begin n_err++; $display("FAIL ovf_count: got %0d expected 11", char_count); end
        n_cmp++; if (buffer_full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b expected 1", buffer_full); end
        for (int i = 0; i < GUARD + 3; i++) begin
            tick(0, 0, 8'h00, 1);
            if (overflow) ovf++;
        end
        n_cmp++; if (ovf != 1) begin n_err++; $display("FAIL ovf_count_pulses: got %0d expected 1", ovf); end
        n_cmp++; if (sequence_[7:0] !== 8'h6B) begin n_err++; $display("FAIL ovf_slot10: got %h expected 6b", sequence_[7:0]); end
    endtask

    task automatic test_backspace();
        int plots;
        tick(1, 0, 8'h00, 0);
        for (int i = 0; i < GUARD + 3; i++) tick(0, 0, 8'h00, 1);
        tick(0, 1, 8'h41, 0);
        tick(0, 1, 8'h42, 0);
        tick(0, 1, 8'h08, 0);
        tick(0, 1, 8'h08, 0);
        plots = 0;
        for (int i = 0; i < GUARD + 3; i++) begin tick(0, 0, 8'h00, 1); if (plot_sequence) plots++; end
        n_cmp++; if (plots != 1) begin n_err++; $display("FAIL bs_plots: got %0d expected 1", plots); end
        plots = 0;
        tick(0, 1, 8'h08, 1);   // backspace on empty buffer: no edit, no redraw
        for (int i = 0; i < GUARD + 3; i++) begin tick(0, 0, 8'h00, 1); if (plot_sequence) plots++; end
        n_cmp++; if (plots != 0) begin n_err++; $display("FAIL bs_empty_plots: got %0d expected 0", plots); end
        n_cmp++; if (char_count !== 4'd0) begin n_err++; $display("FAIL bs_count: got %0d expected 0", char_count); end
        n_cmp++; if (sequence_ !== {11{PAD}}) begin n_err++; $display("FAIL bs_seq: got %h expected %h", sequence_, {11{PAD}}); end
    endtask

    task automatic test_enter();
        int plots;
        tick(1, 0, 8'h00, 0);
        tick(0, 1, 8'h48, 0);
        tick(0, 1, 8'h49, 0);
        tick(0, 1, 8'h0D, 0);
        n_cmp++; if (submit !== 1'b1) begin n_err++; $display("FAIL enter_submit: got %b expected 1", submit); end
        n_cmp++; if (submit_sequence !== {16'h4849, {9{PAD}}}) begin n_err++; $display("FAIL enter_subseq: got %h expected %h", submit_sequence, {16'h4849, {9{PAD}}}); end
        n_cmp++; if (char_count !== 4'd0) begin n_err++; $display("FAIL enter_count: got %0d expected 0", char_count); end
        tick(0, 0, 8'h00, 1);
        n_cmp++; if (submit !== 1'b0) begin n_err++; $display("FAIL enter_single: got %b expected 0", submit); end
        plots = (plot_sequence === 1'b1) ? 1 : 0;
        for (int i = 0; i < GUARD + 3; i++) begin tick(0, 0, 8'h00, 1); if (plot_sequence) plots++; end
        n_cmp++; if (plots != 1) begin n_err++; $display("FAIL enter_redraw: got %0d expected 1", plots); end
        n_cmp++; if (sequence_ !== {11{PAD}}) begin n_err++; $display("FAIL enter_blank: got %h expected %h", sequence_, {11{PAD}}); end
    endtask

    task automatic test_request_edit();
        int gap;
        bit seen;
        tick(1, 0, 8'h00, 0);
        tick(0, 0, 8'h00, 1);
        n_cmp++; if (plot_sequence !== 1'b1) begin n_err++; $display("FAIL req_first: got %b expected 1", plot_sequence); end
        tick(0, 1, 8'h51, 1);   // key during the REQUEST cycle
        n_cmp++; if (sequence_ !== {11{PAD}}) begin n_err++; $display("FAIL req_excluded: got %h expected %h", sequence_, {11{PAD}}); end
        gap = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(0, 0, 8'h00, 1);
            gap++;
            if (plot_sequence) seen = 1'b1;
        end
        n_cmp++; if (!seen || gap != int'(GUARD) + 1) begin n_err++; $display("FAIL req_gap: got %0d (seen=%b) expected %0d", gap, seen, GUARD + 1); end
        n_cmp++; if (sequence_[87:80] !== 8'h51) begin n_err++; $display("FAIL req_second_snap: got %h expected 51", sequence_[87:80]); end
    endtask

    task automatic test_random();
        bit rst, kv, rdy;
        logic [7:0] kc;
        int r;
        tick(1, 0, 8'h00, 0);
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            kv  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 19);
            if (r < 12)       kc = 8'($urandom_range(32, 126));
            else if (r < 15)  kc = 8'h08;
            else if (r == 15) kc = 8'h0D;
            else if (r < 18)  kc = 8'($urandom_range(0, 31));
            else              kc = 8'($urandom_range(127, 255));
            tick(rst, kv, kc, rdy);
            n_cmp++; if (plot_sequence !== m_plot) begin n_err++; $display("FAIL rnd_plot@%0d: got %b expected %b", i, plot_sequence, m_plot); end
            n_cmp++; if (char_count !== 4'(m_buf.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d expected %0d", i, char_count, m_buf.size()); end
            n_cmp++; if (buffer_full !== (m_buf.size() == 11)) begin n_err++; $display("FAIL rnd_full@%0d: got %b expected %b", i, buffer_full, m_buf.size() == 11); end
            n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b expected %b", i, overflow, m_ovf); end
            n_cmp++; if (submit !== m_sub) begin n_err++; $display("FAIL rnd_submit@%0d: got %b expected %b", i, submit, m_sub); end
            n_cmp++; if (sequence_ !== m_snap) begin n_err++; $display("FAIL rnd_seq@%0d: got %h expected %h", i, sequence_, m_snap); end
            n_cmp++; if (submit_sequence !== m_subseq) begin n_err++; $display("FAIL rnd_subseq@%0d: got %h expected %h", i, submit_sequence, m_subseq); end
        end
    endtask

    initial begin
        test_reset();
        test_blank_plot();
        test_cat();
        test_overflow();
        test_backspace();
        test_enter();
        test_request_edit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
